// File: rtl/frame_hdr_pkg.sv
// Shared types and header layout for the multi-channel frame header inserter.
package frame_hdr_pkg;

    typedef enum logic {
        WAIT_HDR = 1'b0,
        PAYLOAD  = 1'b1
    } state_t;

    localparam int SEQ_LSB = 0;
    localparam int SEQ_W   = 32;
    localparam int CH_LSB  = 32;
    localparam int CH_W    = 8;
    localparam int LEN_LSB = 40;
    localparam int LEN_W   = 16;

    // Low 64 bits of an auto-generated header; everything above is zero.
    function automatic logic [63:0] auto_hdr(input logic [SEQ_W-1:0] seq,
                                             input logic [CH_W-1:0]  ch,
                                             input logic [LEN_W-1:0] len);
        logic [63:0] hdr;
        hdr = '0;
        hdr[SEQ_LSB +: SEQ_W] = seq;
        hdr[CH_LSB  +: CH_W]  = ch;
        hdr[LEN_LSB +: LEN_W] = len;
        return hdr;
    endfunction

endpackage

// File: rtl/frame_hdr_channel.sv
// One framer channel: header/payload FSM, beat counter, registered AXI-Stream
// output stage and sticky length-error flag.
module frame_hdr_channel
    import frame_hdr_pkg::*;
#(
    parameter int DW          = 128,
    parameter int FRAME_BEATS = 128
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_fire,
    input  logic [DW-1:0]   i_hdr,
    output logic            o_wait_free,
    input  logic [DW-1:0]   s_tdata,
    input  logic            s_tvalid,
    input  logic            s_tlast,
    output logic            s_tready,
    output logic [DW-1:0]   m_tdata,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic            m_tlast,
    output logic [DW/8-1:0] m_tkeep,
    output logic            err_len
);

    localparam int CW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_tdata;
    logic            r_tvalid;
    logic            r_tlast;
    logic            r_err;
    logic            w_free;
    logic            w_last;
    logic            w_tready;
    logic            w_hs;

    assign w_free = !r_tvalid || m_tready;
    assign w_last = (r_cnt == CW'(FRAME_BEATS - 1));
    assign w_hs   = w_tready && s_tvalid;

    always_comb begin
        w_state_nxt = r_state;
        w_tready    = 1'b0;
        case (r_state)
            WAIT_HDR: begin
                if (i_fire) w_state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                w_tready = w_free;
                if (w_tready && s_tvalid && w_last) w_state_nxt = WAIT_HDR;
            end
            default: w_state_nxt = WAIT_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= WAIT_HDR;
        else         r_state <= w_state_nxt;
    end

    // Output stage: header load, payload load, or drain when accepted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (i_fire) begin
                r_tdata  <= i_hdr;
                r_tvalid <= 1'b1;
                r_tlast  <= 1'b0;
                r_cnt    <= '0;
            end else if (w_hs) begin
                r_tdata  <= s_tdata;
                r_tvalid <= 1'b1;
                r_tlast  <= w_last;
                r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
                if (s_tlast != w_last) r_err <= 1'b1;
            end else if (m_tready) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
        end
    end

    assign o_wait_free = (r_state == WAIT_HDR) && w_free;
    assign s_tready    = w_tready;
    assign m_tdata     = r_tdata;
    assign m_tvalid    = r_tvalid;
    assign m_tlast     = r_tlast;
    assign m_tkeep     = {(DW/8){r_tvalid}};
    assign err_len     = r_err;

endmodule

// File: rtl/frame_header_inserter.sv
// Multi-channel AXI-Stream framer: one header beat per FRAME_BEATS payload
// beats on every channel, headers started in lockstep across channels.
module frame_header_inserter
    import frame_hdr_pkg::*;
#(
    parameter int DW          = 128,
    parameter int N_CH        = 2,
    parameter int FRAME_BEATS = 128,
    parameter int HDR_MODE    = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [DW-1:0]          s_meta_tdata,
    input  logic                   s_meta_tvalid,
    output logic                   s_meta_tready,
    input  logic [N_CH*DW-1:0]     s_tdata,
    input  logic [N_CH-1:0]        s_tvalid,
    input  logic [N_CH-1:0]        s_tlast,
    output logic [N_CH-1:0]        s_tready,
    output logic [N_CH*DW-1:0]     m_tdata,
    output logic [N_CH-1:0]        m_tvalid,
    input  logic [N_CH-1:0]        m_tready,
    output logic [N_CH-1:0]        m_tlast,
    output logic [N_CH*DW/8-1:0]   m_tkeep,
    output logic [N_CH-1:0]        err_len
);

    logic [N_CH-1:0] w_wait_free;
    logic            w_fire;
    logic [31:0]     r_seq;

    // A frame only starts once every channel has drained its previous frame.
    assign w_fire        = (&w_wait_free) && ((HDR_MODE != 0) || s_meta_tvalid);
    assign s_meta_tready = (HDR_MODE == 0) ? w_fire : 1'b0;

    always_ff @(posedge clk) begin
        if (!resetn)     r_seq <= '0;
        else if (w_fire) r_seq <= r_seq + 32'd1;
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [DW-1:0] w_hdr;

        assign w_hdr = (HDR_MODE != 0)
                     ? DW'(auto_hdr(r_seq, 8'(gi), 16'(FRAME_BEATS)))
                     : s_meta_tdata;

        frame_hdr_channel #(
            .DW          (DW),
            .FRAME_BEATS (FRAME_BEATS)
        ) u_ch (
            .clk         (clk),
            .resetn      (resetn),
            .i_fire      (w_fire),
            .i_hdr       (w_hdr),
            .o_wait_free (w_wait_free[gi]),
            .s_tdata     (s_tdata[gi*DW +: DW]),
            .s_tvalid    (s_tvalid[gi]),
            .s_tlast     (s_tlast[gi]),
            .s_tready    (s_tready[gi]),
            .m_tdata     (m_tdata[gi*DW +: DW]),
            .m_tvalid    (m_tvalid[gi]),
            .m_tready    (m_tready[gi]),
            .m_tlast     (m_tlast[gi]),
            .m_tkeep     (m_tkeep[gi*(DW/8) +: DW/8]),
            .err_len     (err_len[gi])
        );
    end

endmodule

// File: tb/tb_frame_header_inserter.sv
// Directed bench for frame_header_inserter: three configurations share one
// stimulus driver and one cycle-level scoreboard.
module tb_frame_header_inserter;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [127:0] s_meta_tdata = '0;
    logic         s_meta_tvalid = 1'b0;
    logic [255:0] s_tdata = '0;
    logic [1:0]   s_tvalid = '0;
    logic [1:0]   s_tlast = '0;
    logic [1:0]   m_tready = 2'b11;

    logic [255:0] m_tdata_d [3];
    logic [1:0]   m_tvalid_d [3];
    logic [1:0]   m_tlast_d [3];
    logic [31:0]  m_tkeep_d [3];
    logic [1:0]   s_tready_d [3];
    logic [1:0]   err_len_d [3];
    logic         s_meta_tready_d [3];

    always #5 clk = ~clk;

    frame_header_inserter #(.DW(128), .N_CH(2), .FRAME_BEATS(4), .HDR_MODE(0)) dut_meta (
        .clk(clk), .resetn(resetn),
        .s_meta_tdata(s_meta_tdata), .s_meta_tvalid(s_meta_tvalid), .s_meta_tready(s_meta_tready_d[0]),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready_d[0]),
        .m_tdata(m_tdata_d[0]), .m_tvalid(m_tvalid_d[0]), .m_tready(m_tready),
        .m_tlast(m_tlast_d[0]), .m_tkeep(m_tkeep_d[0]), .err_len(err_len_d[0]));

    frame_header_inserter #(.DW(128), .N_CH(2), .FRAME_BEATS(4), .HDR_MODE(1)) dut_auto (
        .clk(clk), .resetn(resetn),
        .s_meta_tdata(s_meta_tdata), .s_meta_tvalid(s_meta_tvalid), .s_meta_tready(s_meta_tready_d[1]),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready_d[1]),
        .m_tdata(m_tdata_d[1]), .m_tvalid(m_tvalid_d[1]), .m_tready(m_tready),
        .m_tlast(m_tlast_d[1]), .m_tkeep(m_tkeep_d[1]), .err_len(err_len_d[1]));

    frame_header_inserter #(.DW(128), .N_CH(2), .FRAME_BEATS(1), .HDR_MODE(0)) dut_short (
        .clk(clk), .resetn(resetn),
        .s_meta_tdata(s_meta_tdata), .s_meta_tvalid(s_meta_tvalid), .s_meta_tready(s_meta_tready_d[2]),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready_d[2]),
        .m_tdata(m_tdata_d[2]), .m_tvalid(m_tvalid_d[2]), .m_tready(m_tready),
        .m_tlast(m_tlast_d[2]), .m_tkeep(m_tkeep_d[2]), .err_len(err_len_d[2]));

    int n_chk = 0;
    int n_fail = 0;

    int sel, fb, nfr, err_beat, stop_in, cyc, meta_sent;
    bit mode1, rnd1;
    int in_idx [2];
    int acc [2];
    bit prev_stall [2];
    logic [127:0] prev_data [2];
    logic prev_last [2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pay(input int f, input int c, input int b);
        return 128'(f * 100 + c * 10 + b + 1);
    endfunction

    function automatic logic [127:0] meta(input int f);
        return {16{8'hA5}} ^ 128'(f);
    endfunction

    function automatic logic [127:0] auto_h(input int f, input int c, input int len);
        logic [127:0] h;
        h = '0;
        h[31:0]  = f;
        h[39:32] = c[7:0];
        h[55:40] = len[15:0];
        return h;
    endfunction

    task automatic init_bk();
        for (int c = 0; c < 2; c++) begin
            in_idx[c] = 0;
            acc[c] = 0;
            prev_stall[c] = 1'b0;
        end
        meta_sent = 0;
        cyc = 0;
        stop_in = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        s_tvalid = '0;
        s_tlast = '0;
        s_meta_tvalid = 1'b0;
        m_tready = 2'b11;
        @(negedge clk);
        resetn = 1'b1;
        init_bk();
    endtask

    task automatic step();
        logic [255:0] md;
        logic [31:0]  mk;
        logic [1:0]   mv, ml, st;
        logic         smr, hs;
        logic [127:0] ed;
        logic         el;
        int n, f, b, k, p;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            n = in_idx[c];
            f = n / fb;
            b = n % fb;
            s_tvalid[c] = (n < nfr * fb);
            s_tdata[c*128 +: 128] = pay(f, c, b);
            s_tlast[c] = (b == fb - 1) || (c == 0 && n == err_beat);
        end
        s_meta_tvalid = !mode1 && (meta_sent < nfr);
        s_meta_tdata = meta(meta_sent);
        m_tready = {rnd1 ? 1'($urandom_range(1)) : 1'b1, 1'b1};
        #1;
        md = m_tdata_d[sel];
        mk = m_tkeep_d[sel];
        mv = m_tvalid_d[sel];
        ml = m_tlast_d[sel];
        st = s_tready_d[sel];
        smr = s_meta_tready_d[sel];
        if (mode1) chk("meta_ready_auto", smr, 1'b0);
        if (s_meta_tvalid && smr)
            for (int c = 0; c < 2; c++)
                chk($sformatf("hdr_lockstep ch%0d", c), acc[c] + int'(mv[c] && m_tready[c]),
                    meta_sent * (fb + 1));
        for (int c = 0; c < 2; c++) begin
            if (prev_stall[c]) begin
                chk($sformatf("hold_valid ch%0d", c), mv[c], 1'b1);
                chk($sformatf("hold_data ch%0d", c), md[c*128 +: 128], prev_data[c]);
                chk($sformatf("hold_last ch%0d", c), ml[c], prev_last[c]);
            end
            if (mv[c]) chk($sformatf("tkeep ch%0d", c), mk[c*16 +: 16], 16'hFFFF);
            hs = mv[c] && m_tready[c];
            if (hs) begin
                k = acc[c];
                f = k / (fb + 1);
                p = k % (fb + 1);
                if (p == 0) ed = mode1 ? auto_h(f, c, fb) : meta(f);
                else        ed = pay(f, c, p - 1);
                el = (p == fb);
                chk($sformatf("out_data ch%0d beat%0d", c, k), md[c*128 +: 128], ed);
                chk($sformatf("out_last ch%0d beat%0d", c, k), ml[c], el);
                acc[c]++;
            end
            prev_stall[c] = mv[c] && !m_tready[c];
            prev_data[c] = md[c*128 +: 128];
            prev_last[c] = ml[c];
            if (s_tvalid[c] && st[c]) in_idx[c]++;
        end
        if (s_meta_tvalid && smr) meta_sent++;
        cyc++;
    endtask

    task automatic run();
        int tot;
        tot = nfr * (fb + 1);
        while ((acc[0] < tot || acc[1] < tot) && cyc < 400 &&
               !(stop_in > 0 && in_idx[0] >= stop_in))
            step();
        if (stop_in == 0)
            for (int c = 0; c < 2; c++)
                chk($sformatf("frame_count ch%0d", c), acc[c], tot);
    endtask

    initial begin
        err_beat = -1;
        rnd1 = 1'b0;

        // Reset state and basic meta-header framing.
        sel = 0; fb = 4; mode1 = 1'b0; nfr = 2;
        do_reset();
        #1;
        chk("rst_m_tvalid", m_tvalid_d[0], 2'b00);
        chk("rst_m_tlast", m_tlast_d[0], 2'b00);
        chk("rst_m_tdata", m_tdata_d[0][127:0] | m_tdata_d[0][255:128], 128'd0);
        chk("rst_m_tkeep", m_tkeep_d[0], 32'd0);
        chk("rst_err_len", err_len_d[0], 2'b00);
        chk("rst_s_tready", s_tready_d[0], 2'b00);
        run();
        chk("basic_cycles", cyc, 11);
        chk("basic_meta_used", meta_sent, 2);
        chk("basic_err_len", err_len_d[0], 2'b00);

        // Random backpressure on channel 1.
        do_reset();
        nfr = 3; rnd1 = 1'b1;
        run();
        chk("bp_meta_used", meta_sent, 3);
        chk("bp_err_len", err_len_d[0], 2'b00);
        rnd1 = 1'b0;

        // Early s_tlast on ch0 beat 2: sticky error, framing unchanged.
        do_reset();
        nfr = 2; err_beat = 1;
        run();
        chk("len_err_sticky", err_len_d[0], 2'b01);
        err_beat = -1;

        // Auto header mode: sequence, channel id, length.
        sel = 1; mode1 = 1'b1;
        do_reset();
        nfr = 3;
        run();

        // Reset mid-frame, then a clean frame restarting at sequence 0.
        do_reset();
        nfr = 2; err_beat = 0;
        stop_in = fb + 2;
        run();
        chk("pre_rst_err", err_len_d[1], 2'b01);
        do_reset();
        #1;
        chk("midrst_m_tvalid", m_tvalid_d[1], 2'b00);
        chk("midrst_s_tready", s_tready_d[1], 2'b00);
        chk("midrst_err_len", err_len_d[1], 2'b00);
        err_beat = -1; nfr = 1;
        run();
        chk("post_rst_err", err_len_d[1], 2'b00);

        // One-beat frames back to back.
        sel = 2; fb = 1; mode1 = 1'b0;
        do_reset();
        nfr = 4;
        run();
        chk("short_cycles", cyc, 9);
        chk("short_meta_used", meta_sent, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
